// File: rtl/apb4_master_if.sv
// Bundle of request/response channel and APB4 bus signals around apb4_master.
// The master modport is the requester's view; the slave modport is the opposite side.
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [2:0]            req_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb4_master.sv
// APB4 requester: one valid/ready request becomes one SETUP/ACCESS transfer,
// with the result returned on a valid/ready response channel and a PREADY timeout.
module apb4_master #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    apb4_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  rsp_timeout_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic [STRB_WIDTH-1:0] pstrb_r;
    logic [2:0]            pprot_r;
    logic                  timeout_hit_s;

    // A zero TIMEOUT_CYCLES keeps the compare permanently false.
    assign timeout_hit_s = (TIMEOUT_CYCLES > 0) && (cnt_r == CNT_LAST);

    // Transfer sequencer; every output is a register written only here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            pstrb_r       <= '0;
            pprot_r       <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        paddr_r     <= bus.req_addr;
                        pwrite_r    <= bus.req_write;
                        pwdata_r    <= bus.req_wdata;
                        pstrb_r     <= bus.req_write ? bus.req_strb : '0;
                        pprot_r     <= bus.req_prot;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        req_ready_r <= 1'b0;
                        cnt_r       <= '0;
                        state_r     <= SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        rsp_rdata_r   <= pwrite_r ? '0 : bus.prdata;
                        rsp_err_r     <= bus.pslverr;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        state_r       <= RESP;
                    end else if (timeout_hit_s) begin
                        rsp_rdata_r   <= '0;
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        state_r       <= RESP;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.psel        = psel_r;
    assign bus.penable     = penable_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.pstrb       = pstrb_r;
    assign bus.pprot       = pprot_r;
endmodule

// File: tb/tb_apb4_master.sv
// Bench for apb4_master: directed and random transfers against a per-transfer
// response model derived from wait-state count, slave error and timeout limit.
module tb_apb4_master;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apb4_master_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

    apb4_master #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle after the response handshake.
    task automatic xfer(input logic [2:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] sb, input logic [2:0] pr, input int waits,
                        input logic serr, input logic [31:0] rd, input int rdly,
                        input bit immediate);
        logic        exp_to;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_strb;
        int          n;
        int          acc;
        exp_to    = (TO > 0) && (waits >= TO);
        exp_acc   = exp_to ? TO : waits + 1;
        exp_rdata = (exp_to || w) ? 32'h0 : rd;
        exp_err   = exp_to | serr;
        exp_strb  = w ? sb : 4'h0;

        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = wd;
        bus.req_strb  = sb;
        bus.req_prot  = pr;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_bound", {31'd0, n < 20}, 32'd1);
        if (immediate) chk("req_ready_immediate", n, 32'd0);

        // SETUP cycle; request lines now carry noise that must be ignored
        @(negedge clk);
        bus.req_addr  = 3'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_wdata = $urandom;
        bus.req_strb  = 4'($urandom);
        bus.req_prot  = 3'($urandom);
        chk("setup_psel", {31'd0, bus.psel}, 32'd1);
        chk("setup_penable", {31'd0, bus.penable}, 32'd0);
        chk("setup_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("setup_paddr", {29'd0, bus.paddr}, {29'd0, a});
        chk("setup_pwrite", {31'd0, bus.pwrite}, {31'd0, w});
        chk("setup_pwdata", bus.pwdata, wd);
        chk("setup_pstrb", {28'd0, bus.pstrb}, {28'd0, exp_strb});
        chk("setup_pprot", {29'd0, bus.pprot}, {29'd0, pr});
        bus.pready  = 1'($urandom);
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;

        acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!(bus.psel === 1'b1 && bus.penable === 1'b1)) break;
            acc++;
            chk("access_paddr", {29'd0, bus.paddr}, {29'd0, a});
            chk("access_pwdata", bus.pwdata, wd);
            chk("access_pstrb", {28'd0, bus.pstrb}, {28'd0, exp_strb});
            chk("access_pwrite", {31'd0, bus.pwrite}, {31'd0, w});
            chk("access_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            bus.pready  = (acc == waits + 1);
            bus.prdata  = bus.pready ? rd : $urandom;
            bus.pslverr = bus.pready ? serr : 1'($urandom);
        end

        chk("access_cycles", acc, exp_acc);
        chk("resp_psel", {31'd0, bus.psel}, 32'd0);
        chk("resp_penable", {31'd0, bus.penable}, 32'd0);
        chk("resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("resp_rdata", bus.rsp_rdata, exp_rdata);
        chk("resp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk("resp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp_to});
        chk("resp_paddr_hold", {29'd0, bus.paddr}, {29'd0, a});
        bus.pready  = 1'($urandom);
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;

        for (int d = 0; d < rdly; d++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("bp_rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
            chk("bp_rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp_to});
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_psel", {31'd0, bus.psel}, 32'd0);
            bus.pready = 1'($urandom);
            bus.prdata = $urandom;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_psel", {31'd0, bus.psel}, 32'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 3'h0;
        bus.req_write = 1'b0;
        bus.req_wdata = 32'h0;
        bus.req_strb  = 4'h0;
        bus.req_prot  = 3'h0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_psel", {31'd0, bus.psel}, 32'd0);
        chk("rst_penable", {31'd0, bus.penable}, 32'd0);
        chk("rst_paddr", {29'd0, bus.paddr}, 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);
        chk("rst_pstrb", {28'd0, bus.pstrb}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write, read with 3 wait states, slave error
        xfer(3'h5, 1'b1, 32'hDEADBEEF, 4'hF, 3'h2, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
        xfer(3'h2, 1'b0, 32'h0BAD_F00D, 4'hF, 3'h1, 3, 1'b0, 32'hA5A5_0001, 1, 1'b1);
        xfer(3'h7, 1'b1, 32'h0000_00FF, 4'h3, 3'h0, 1, 1'b1, 32'hFFFF_FFFF, 0, 1'b1);
        // Timeout with pready never high, then pready on the 16th ACCESS cycle
        xfer(3'h1, 1'b0, 32'h0, 4'hF, 3'h4, 40, 1'b0, 32'hCAFE_CAFE, 0, 1'b1);
        xfer(3'h1, 1'b0, 32'h0, 4'hF, 3'h4, TO - 1, 1'b0, 32'hCAFE_0016, 0, 1'b1);
        // Back-to-back with response backpressure
        xfer(3'h3, 1'b1, 32'h1111_2222, 4'hA, 3'h5, 0, 1'b0, 32'h0, 5, 1'b1);
        xfer(3'h4, 1'b0, 32'h3333_4444, 4'h5, 3'h6, 2, 1'b0, 32'h5555_6666, 5, 1'b1);

        // Reset during ACCESS wait states
        bus.req_valid = 1'b1;
        bus.req_addr  = 3'h6;
        bus.req_write = 1'b0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.pready = 1'b0;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_psel", {31'd0, bus.psel}, 32'd1);
        chk("pre_rst_penable", {31'd0, bus.penable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_psel", {31'd0, bus.psel}, 32'd0);
        chk("mid_rst_penable", {31'd0, bus.penable}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(3'h2, 1'b0, 32'h0, 4'hF, 3'h0, 1, 1'b0, 32'h0DD0_BEEF, 0, 1'b0);

        // Random transfers; waits span both sides of the timeout limit
        for (int i = 0; i < 40; i++) begin
            xfer(3'($urandom), 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 20)), 1'($urandom), $urandom,
                 int'($urandom_range(0, 4)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
APB4 requester (initiator) that turns single-beat requests from an internal valid/ready request channel into compliant APB4 SETUP/ACCESS transfers. It returns read data and error status on a valid/ready response channel. Sits between a CPU/debug-side agent and the APB4 peripheral fabric holding the register-bank slaves. One transfer in flight at a time, with a programmable PREADY timeout.

Parameters:
ADDR_WIDTH, 3, width of req_addr/paddr
DATA_WIDTH, 32, width of data buses; must be a multiple of 8
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready before abort; 0 disables timeout

Ports:
clk  in  1  sole clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when high with req_valid
req_addr  in  ADDR_WIDTH  target address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte enables
req_prot  in  3  protection attributes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel, penable, pwrite  out  1 each  APB4 control
paddr  out  ADDR_WIDTH  APB4 address
pwdata  out  DATA_WIDTH  APB4 write data
pstrb  out  DATA_WIDTH/8  APB4 strobes
pprot  out  3  APB4 protection
pready, pslverr  in  1 each  APB4 completion/error
prdata  in  DATA_WIDTH  APB4 read data

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: all outputs 0. State returns to IDLE and the timeout counter clears.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1; no other state drives req_ready high.
  - On req_valid&&req_ready, capture addr/write/wdata/strb/prot into paddr/pwrite/pwdata/pstrb/pprot, then go to SETUP.
  - For reads, pstrb is captured as 0, regardless of req_strb.
- SETUP (exactly 1 cycle): psel=1, penable=0, then go to ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata/pstrb/pprot are held stable for the whole transfer.
- pready sampled high in ACCESS:
  - Register rsp_rdata = prdata for reads, 0 for writes.
  - Register rsp_err = pslverr and rsp_timeout = 0.
  - Drop psel/penable next cycle and go to RESP.
- Timeout:
  - The counter increments on each ACCESS cycle with pready=0.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with pready=0: rsp_err=1, rsp_timeout=1, rsp_rdata=0; drop psel/penable; go to RESP.
  - pready on that same cycle wins over timeout.
  - The counter clears on entry to SETUP.
- RESP: rsp_valid=1 and response fields held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE; rsp_valid=0 next cycle.
- Zero-wait-state latency: accept edge T0 → SETUP cycle T1 → ACCESS cycle T2 (pready=1) → rsp_valid from T3. Next accept is at the earliest T4 (IDLE after handshake). APB bus is idle (psel=0) at least 1 cycle between transfers.
- All APB outputs are registered; no combinational path from pready/prdata to any output.
- paddr/pwrite/pwdata/pstrb/pprot hold their last values while psel=0.
- Signals ignored outside their states: pready/pslverr/prdata outside ACCESS, and req_valid outside IDLE.
- Reset asserted mid-transfer: psel/penable fall asynchronously and any pending response is discarded.
- Counter width is clog2(TIMEOUT_CYCLES+1) with a minimum of 1; it saturates and never wraps.

Test Plan:
- Write: req addr=3'h5, wdata=32'hDEADBEEF, strb=4'hF, pready=1 immediately → psel T1, penable T2, pwdata=DEADBEEF, pstrb=F; rsp_valid T3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=3'h2, strb=4'hF, pready high on 4th ACCESS cycle with prdata=32'hA5A5_0001 → pstrb=0 throughout, penable high 4 cycles, rsp_rdata=A5A50001, rsp_err=0.
- Slave error: write with pslverr=1 alongside pready → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, pready held 0 → psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready on cycle 16 → normal completion.
- Backpressure/back-to-back: two queued requests, rsp_ready low 5 cycles → rsp fields stable, req_ready=0 until handshake; second SETUP begins 2 cycles after rsp handshake; psel low ≥1 cycle between transfers.
- Reset mid-ACCESS: assert rst during wait states → psel/penable/rsp_valid 0 immediately; after release, a new read completes normally.
